decode_to_fetch: RTL
====================

DECODE_TO_FETCH -- requirements
Module: decode_to_fetch

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are listed in REQ-002..REQ-018.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 BranchTaken  input  1  branch in ID resolved taken this cycle.
REQ-005 BranchTarget  input  32  branch target address from ID.
REQ-006 Jump  input  1  jump in ID this cycle.
REQ-007 JumpTarget  input  32  jump target address from ID.
REQ-008 IDEX_MemRead  input  1  instruction in EX is a load.
REQ-009 IDEX_Rt  input  5  destination register of the load in EX.
REQ-010 IFID_Rs, IFID_Rt  input  5 each  source registers of the instruction in ID.
REQ-011 PCWrite  output  1  PC update enable to fetch.
REQ-012 IFIDWrite  output  1  IF/ID register load enable.
REQ-013 IFIDFlush  output  1  zero IF/ID contents at next edge.
REQ-014 IDEXBubble  output  1  insert NOP into ID/EX at next edge.
REQ-015 PCSrc  output  1  1 = fetch loads PCTarget instead of PC+4.
REQ-016 PCTarget  output  32  registered redirect address.
REQ-017 StallCount  output  16  load-use stall cycles since reset, saturating.
REQ-018 FlushCount  output  16  redirects since reset, saturating.

Function
REQ-019 SHALL implement FSM states RUN and REDIRECT; PCTarget, state and both counters are registers; all other outputs are combinational from state and inputs.
REQ-020 Hazard = IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt).
REQ-021 RUN, Hazard = 1: PCWrite = 0, IFIDWrite = 0, IDEXBubble = 1, IFIDFlush = 0, PCSrc = 0.
- Branch/Jump ignored this cycle.
- StallCount += 1.
- Stay in RUN.
REQ-022 RUN, Hazard = 0, Jump = 1: PCTarget <= JumpTarget; go to REDIRECT. Jump has priority over BranchTaken.
REQ-023 RUN, Hazard = 0, Jump = 0, BranchTaken = 1: PCTarget <= BranchTarget; go to REDIRECT.
REQ-024 RUN, no hazard/branch/jump: PCWrite = 1, IFIDWrite = 1, all others 0.
REQ-025 REDIRECT, lasting exactly one cycle: PCSrc = 1, PCWrite = 1, IFIDWrite = 1, IFIDFlush = 1, IDEXBubble = 1.
- Hazard, Jump and BranchTaken ignored (wrong-path instruction).
- FlushCount += 1.
- Next state RUN.
REQ-026 Redirect latency: branch/jump seen in RUN at edge N; PCSrc = 1 with the target during cycle N+1; the fetch PC equals the target after edge N+1.
REQ-027 Counters saturate at 16'hFFFF and never wrap.
REQ-028 Back-to-back case: a branch in the first RUN cycle after REDIRECT is accepted normally.
REQ-029 PCTarget holds its value except on a transition into REDIRECT.

Reset
REQ-030 rst_n low forces, immediately and regardless of clk:
- state = RUN
- PCTarget = 0
- StallCount = 0, FlushCount = 0
- PCWrite = 0, IFIDWrite = 0, IFIDFlush = 0, IDEXBubble = 0, PCSrc = 0
REQ-031 Reset asserted in REDIRECT SHALL abort the redirect. After release, the first cycle is RUN with PCSrc = 0.
REQ-032 On rst_n rising, outputs follow REQ-024 in the same cycle if there is no hazard or branch.

Verification
REQ-033 Load-use: IDEX_MemRead = 1, IDEX_Rt = 5, IFID_Rs = 5 for one cycle -> PCWrite = 0, IFIDWrite = 0, IDEXBubble = 1 that cycle; StallCount = 1.
REQ-034 Rt = 0: IDEX_MemRead = 1, IDEX_Rt = 0, IFID_Rs = 0 -> no stall; PCWrite = 1; StallCount unchanged.
REQ-035 Branch: BranchTaken = 1, BranchTarget = 32'h0000_0040 at edge N -> during cycle N+1: PCSrc = 1, PCTarget = 32'h40, IFIDFlush = 1; cycle N+2 back to REQ-024 outputs; FlushCount = 1.
REQ-036 Priority: Jump = 1 (JumpTarget = 32'h100) and BranchTaken = 1 (BranchTarget = 32'h40) together -> PCTarget = 32'h100. Hazard + BranchTaken together -> stall only; branch taken the following cycle -> redirect.
REQ-037 Saturation: hold Hazard true for 65,540 cycles -> StallCount = 16'hFFFF and stays there.
REQ-038 Reset mid-redirect: assert rst_n = 0 during REDIRECT -> PCSrc = 0 immediately; after release, PCTarget = 0 and FlushCount = 0.

Source files
------------

// File: rtl/decode_to_fetch.sv
// Hazard/redirect controller between decode and fetch: stalls on load-use,
// redirects fetch for one cycle on a taken branch or jump.
module decode_to_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        PCSrc,
    output logic [31:0] PCTarget,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_target_q, pc_target_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic hazard;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pc_src;

    assign hazard = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

    always_comb begin
        state_d       = state_q;
        pc_target_d   = pc_target_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pc_src        = 1'b0;

        case (state_q)
            RUN: begin
                if (hazard) begin
                    // Load-use stall wins over any branch/jump; ID re-presents it next cycle.
                    idex_bubble   = 1'b1;
                    stall_count_d = (stall_count_q == 16'hFFFF) ? stall_count_q
                                                                : stall_count_q + 16'd1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    if (Jump) begin
                        pc_target_d = JumpTarget;
                        state_d     = REDIRECT;
                    end else if (BranchTaken) begin
                        pc_target_d = BranchTarget;
                        state_d     = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                // Instruction now in ID is wrong-path, so its requests are ignored.
                pc_src        = 1'b1;
                pc_write      = 1'b1;
                ifid_write    = 1'b1;
                ifid_flush    = 1'b1;
                idex_bubble   = 1'b1;
                flush_count_d = (flush_count_q == 16'hFFFF) ? flush_count_q
                                                            : flush_count_q + 16'd1;
                state_d       = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_target_q   <= 32'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_target_q   <= pc_target_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Control outputs are forced low while reset is held, independent of the clock.
    assign PCWrite    = rst_n & pc_write;
    assign IFIDWrite  = rst_n & ifid_write;
    assign IFIDFlush  = rst_n & ifid_flush;
    assign IDEXBubble = rst_n & idex_bubble;
    assign PCSrc      = rst_n & pc_src;
    assign PCTarget   = pc_target_q;
    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;

endmodule
